// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset/lock sequencer: state encoding and
// the sizing helper for its shared cycle counter.
package pll_rst_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_DEBOUNCE  = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4
    } state_e;

    // Width able to hold the largest of the four phase lengths, plus one spare bit.
    function automatic int cyc_cnt_width(input int a, input int b, input int c, input int d);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (m < 1) m = 1;
        w = 0;
        while ((1 << w) < m) w = w + 1;
        return w + 1;
    endfunction

endpackage

// File: rtl/pll_lock_rst_gen_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level, with async
// active-high clear so the synchronized value reads 0 during reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_rst_gen.sv
// Reset/lock sequencer for the Ethernet clocking PLL: pulses the PLL reset,
// qualifies pll_lock, and releases a single reset for the downstream MAC logic.
module pll_lock_rst_gen
    import pll_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 125000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 64,
    parameter int SYNC_STAGES        = 2,
    parameter int CNT_W              = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_lock,
    output logic               pll_rst,
    output logic               rst_out,
    output logic               lock_stable,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   lock_loss_cnt,
    output logic [CNT_W-1:0]   timeout_cnt
);

    localparam int CYC_W = cyc_cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                         LOCK_STABLE_CYCLES, RST_HOLD_CYCLES);

    localparam logic [CYC_W-1:0] RST_LAST    = CYC_W'(PLL_RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] TMO_LAST    = CYC_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] HOLD_LAST   = CYC_W'(RST_HOLD_CYCLES - 1);

    logic             lock_sync;
    state_e           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             pll_rst_q, pll_rst_d;
    logic             rst_out_q, rst_out_d;
    logic             stable_q, stable_d;
    logic             loss_inc;
    logic             tmo_inc;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_lock),
        .q_o (lock_sync)
    );

    // Lock loss always beats count completion; in WAIT_LOCK a lock beats the timeout.
    always_comb begin
        state_d  = state_q;
        loss_inc = 1'b0;
        tmo_inc  = 1'b0;
        case (state_q)
            S_PLL_RST: begin
                if (cyc_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_sync) begin
                    state_d = S_DEBOUNCE;
                end else if (cyc_q == TMO_LAST) begin
                    state_d = S_PLL_RST;
                    tmo_inc = 1'b1;
                end
            end
            S_DEBOUNCE: begin
                if (!lock_sync) begin
                    state_d = S_WAIT_LOCK;
                end else if (cyc_q == STABLE_LAST) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!lock_sync) begin
                    state_d  = S_PLL_RST;
                    loss_inc = 1'b1;
                end else if (cyc_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_sync) begin
                    state_d  = S_PLL_RST;
                    loss_inc = 1'b1;
                end
            end
            default: begin
                state_d = S_PLL_RST;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        cyc_d     = '0;
        loss_d    = loss_q;
        tmo_d     = tmo_q;
        pll_rst_d = (state_d == S_PLL_RST);
        rst_out_d = (state_d != S_RUN);
        stable_d  = (state_d == S_RUN);

        if (state_d != state_q) begin
            cyc_d = '0;
        end else if (state_q == S_RUN) begin
            cyc_d = cyc_q;
        end else begin
            cyc_d = cyc_q + CYC_W'(1);
        end

        if (loss_inc && (loss_q != '1)) loss_d = loss_q + CNT_W'(1);
        if (tmo_inc && (tmo_q != '1))   tmo_d  = tmo_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_PLL_RST;
            cyc_q     <= '0;
            loss_q    <= '0;
            tmo_q     <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= 1'b1;
            stable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            loss_q    <= loss_d;
            tmo_q     <= tmo_d;
            pll_rst_q <= pll_rst_d;
            rst_out_q <= rst_out_d;
            stable_q  <= stable_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign rst_out       = rst_out_q;
    assign lock_stable   = stable_q;
    assign state_o       = state_q;
    assign lock_loss_cnt = loss_q;
    assign timeout_cnt   = tmo_q;

endmodule

// File: tb/tb_pll_lock_rst_gen.sv
// Directed bench for pll_lock_rst_gen with short phase lengths; every
// expected value is hand-derived from edge counts after each stimulus change.
module tb_pll_lock_rst_gen;

    localparam int PLL_RST_CYCLES     = 4;
    localparam int LOCK_TIMEOUT       = 100;
    localparam int LOCK_STABLE_CYCLES = 8;
    localparam int RST_HOLD_CYCLES    = 4;
    localparam int SYNC_STAGES        = 2;
    localparam int CNT_W              = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             pll_lock;
    logic             pll_rst;
    logic             rst_out;
    logic             lock_stable;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] lock_loss_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    int compared   = 0;
    int mismatched = 0;

    pll_lock_rst_gen #(
        .PLL_RST_CYCLES     (PLL_RST_CYCLES),
        .LOCK_TIMEOUT       (LOCK_TIMEOUT),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .RST_HOLD_CYCLES    (RST_HOLD_CYCLES),
        .SYNC_STAGES        (SYNC_STAGES),
        .CNT_W              (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_lock      (pll_lock),
        .pll_rst       (pll_rst),
        .rst_out       (rst_out),
        .lock_stable   (lock_stable),
        .state_o       (state_o),
        .lock_loss_cnt (lock_loss_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        pll_lock = 1'b0;
        #2;
        compared++; if (pll_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_pll_rst: got %b want 1", pll_rst); end
        compared++; if (rst_out !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_rst_out: got %b want 1", rst_out); end
        compared++; if (lock_stable !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_lock_stable: got %b want 0", lock_stable); end
        compared++; if (state_o !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_state: got %0d want 0", state_o); end
        compared++; if (lock_loss_cnt !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_loss_cnt: got %0d want 0", lock_loss_cnt); end
        compared++; if (timeout_cnt !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_tmo_cnt: got %0d want 0", timeout_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(3);
        compared++; if (pll_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL release_pll_rst_e3: got %b want 1", pll_rst); end
        compared++; if (state_o !== 3'd0) begin mismatched++; $display("[TB] FAIL release_state_e3: got %0d want 0", state_o); end
        step(1);
        compared++; if (pll_rst !== 1'b0) begin mismatched++; $display("[TB] FAIL release_pll_rst_e4: got %b want 0", pll_rst); end
        compared++; if (state_o !== 3'd1) begin mismatched++; $display("[TB] FAIL release_state_e4: got %0d want 1", state_o); end
    endtask

    task automatic test_lock_acquire;
        step(16);
        pll_lock = 1'b1;
        step(3);
        compared++; if (state_o !== 3'd2) begin mismatched++; $display("[TB] FAIL acq_debounce_e3: got %0d want 2", state_o); end
        step(8);
        compared++; if (state_o !== 3'd3) begin mismatched++; $display("[TB] FAIL acq_hold_e11: got %0d want 3", state_o); end
        step(3);
        compared++; if (rst_out !== 1'b1) begin mismatched++; $display("[TB] FAIL acq_rst_out_e14: got %b want 1", rst_out); end
        compared++; if (lock_stable !== 1'b0) begin mismatched++; $display("[TB] FAIL acq_stable_e14: got %b want 0", lock_stable); end
        step(1);
        compared++; if (rst_out !== 1'b0) begin mismatched++; $display("[TB] FAIL acq_rst_out_e15: got %b want 0", rst_out); end
        compared++; if (lock_stable !== 1'b1) begin mismatched++; $display("[TB] FAIL acq_stable_e15: got %b want 1", lock_stable); end
        compared++; if (state_o !== 3'd4) begin mismatched++; $display("[TB] FAIL acq_state_e15: got %0d want 4", state_o); end
        compared++; if (pll_rst !== 1'b0) begin mismatched++; $display("[TB] FAIL acq_pll_rst_e15: got %b want 0", pll_rst); end
    endtask

    task automatic test_lock_loss;
        pll_lock = 1'b0;
        step(2);
        compared++; if (rst_out !== 1'b0) begin mismatched++; $display("[TB] FAIL loss_rst_out_e2: got %b want 0", rst_out); end
        step(1);
        compared++; if (rst_out !== 1'b1) begin mismatched++; $display("[TB] FAIL loss_rst_out_e3: got %b want 1", rst_out); end
        compared++; if (lock_stable !== 1'b0) begin mismatched++; $display("[TB] FAIL loss_stable_e3: got %b want 0", lock_stable); end
        compared++; if (state_o !== 3'd0) begin mismatched++; $display("[TB] FAIL loss_state_e3: got %0d want 0", state_o); end
        compared++; if (pll_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL loss_pll_rst_e3: got %b want 1", pll_rst); end
        compared++; if (lock_loss_cnt !== 8'd1) begin mismatched++; $display("[TB] FAIL loss_cnt_first: got %0d want 1", lock_loss_cnt); end
        step(3);
        compared++; if (pll_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL loss_pll_rst_e6: got %b want 1", pll_rst); end
        step(1);
        compared++; if (pll_rst !== 1'b0) begin mismatched++; $display("[TB] FAIL loss_pll_rst_e7: got %b want 0", pll_rst); end
        compared++; if (state_o !== 3'd1) begin mismatched++; $display("[TB] FAIL loss_state_e7: got %0d want 1", state_o); end
    endtask

    task automatic test_loss_saturation;
        int exp_cnt;
        for (int n = 2; n <= 300; n++) begin
            pll_lock = 1'b1;
            for (int k = 0; k < 40 && state_o !== 3'd4; k++) step(1);
            compared++; if (state_o !== 3'd4) begin mismatched++; $display("[TB] FAIL sat_reach_run n=%0d: got %0d want 4", n, state_o); end
            pll_lock = 1'b0;
            step(3);
            if (n == 10 || n == 254 || n == 255 || n == 256 || n == 300) begin
                exp_cnt = (n > 255) ? 255 : n;
                compared++; if (lock_loss_cnt !== exp_cnt[CNT_W-1:0]) begin mismatched++; $display("[TB] FAIL sat_loss_cnt n=%0d: got %0d want %0d", n, lock_loss_cnt, exp_cnt); end
            end
        end
        compared++; if (timeout_cnt !== 8'd0) begin mismatched++; $display("[TB] FAIL sat_tmo_cnt: got %0d want 0", timeout_cnt); end
    endtask

    task automatic test_debounce_glitch;
        step(4);
        compared++; if (state_o !== 3'd1) begin mismatched++; $display("[TB] FAIL glitch_wait_start: got %0d want 1", state_o); end
        pll_lock = 1'b1;
        step(3);
        compared++; if (state_o !== 3'd2) begin mismatched++; $display("[TB] FAIL glitch_debounce_e3: got %0d want 2", state_o); end
        step(5);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        compared++; if (state_o !== 3'd2) begin mismatched++; $display("[TB] FAIL glitch_state_e9: got %0d want 2", state_o); end
        step(1);
        compared++; if (state_o !== 3'd2) begin mismatched++; $display("[TB] FAIL glitch_state_e10: got %0d want 2", state_o); end
        step(1);
        compared++; if (state_o !== 3'd1) begin mismatched++; $display("[TB] FAIL glitch_back_to_wait_e11: got %0d want 1", state_o); end
        compared++; if (pll_rst !== 1'b0) begin mismatched++; $display("[TB] FAIL glitch_pll_rst_e11: got %b want 0", pll_rst); end
        compared++; if (rst_out !== 1'b1) begin mismatched++; $display("[TB] FAIL glitch_rst_out_e11: got %b want 1", rst_out); end
        step(1);
        compared++; if (state_o !== 3'd2) begin mismatched++; $display("[TB] FAIL glitch_redebounce_e12: got %0d want 2", state_o); end
        step(11);
        compared++; if (state_o !== 3'd3) begin mismatched++; $display("[TB] FAIL glitch_hold_e23: got %0d want 3", state_o); end
        compared++; if (rst_out !== 1'b1) begin mismatched++; $display("[TB] FAIL glitch_rst_out_e23: got %b want 1", rst_out); end
        step(1);
        compared++; if (state_o !== 3'd4) begin mismatched++; $display("[TB] FAIL glitch_run_e24: got %0d want 4", state_o); end
        compared++; if (rst_out !== 1'b0) begin mismatched++; $display("[TB] FAIL glitch_rst_out_e24: got %b want 0", rst_out); end
        compared++; if (timeout_cnt !== 8'd0) begin mismatched++; $display("[TB] FAIL glitch_tmo_cnt: got %0d want 0", timeout_cnt); end
    endtask

    task automatic test_timeouts;
        pll_lock = 1'b0;
        step(3);
        compared++; if (state_o !== 3'd0) begin mismatched++; $display("[TB] FAIL tmo_loss_state: got %0d want 0", state_o); end
        compared++; if (lock_loss_cnt !== 8'd255) begin mismatched++; $display("[TB] FAIL tmo_loss_cnt_no_wrap: got %0d want 255", lock_loss_cnt); end
        step(4);
        compared++; if (state_o !== 3'd1) begin mismatched++; $display("[TB] FAIL tmo_wait_e7: got %0d want 1", state_o); end
        step(99);
        compared++; if (pll_rst !== 1'b0) begin mismatched++; $display("[TB] FAIL tmo_pll_rst_e106: got %b want 0", pll_rst); end
        compared++; if (timeout_cnt !== 8'd0) begin mismatched++; $display("[TB] FAIL tmo_cnt_e106: got %0d want 0", timeout_cnt); end
        step(1);
        compared++; if (pll_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL tmo_pll_rst_e107: got %b want 1", pll_rst); end
        compared++; if (timeout_cnt !== 8'd1) begin mismatched++; $display("[TB] FAIL tmo_cnt_1: got %0d want 1", timeout_cnt); end
        compared++; if (state_o !== 3'd0) begin mismatched++; $display("[TB] FAIL tmo_state_e107: got %0d want 0", state_o); end
        step(3);
        compared++; if (pll_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL tmo_pll_rst_e110: got %b want 1", pll_rst); end
        step(1);
        compared++; if (pll_rst !== 1'b0) begin mismatched++; $display("[TB] FAIL tmo_pll_rst_e111: got %b want 0", pll_rst); end
        step(100);
        compared++; if (pll_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL tmo_pll_rst_e211: got %b want 1", pll_rst); end
        compared++; if (timeout_cnt !== 8'd2) begin mismatched++; $display("[TB] FAIL tmo_cnt_2: got %0d want 2", timeout_cnt); end
        step(104);
        compared++; if (pll_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL tmo_pll_rst_e315: got %b want 1", pll_rst); end
        compared++; if (timeout_cnt !== 8'd3) begin mismatched++; $display("[TB] FAIL tmo_cnt_3: got %0d want 3", timeout_cnt); end
    endtask

    task automatic test_lock_at_timeout;
        step(101);
        pll_lock = 1'b1;
        step(2);
        compared++; if (state_o !== 3'd1) begin mismatched++; $display("[TB] FAIL edge_still_wait: got %0d want 1", state_o); end
        step(1);
        compared++; if (state_o !== 3'd2) begin mismatched++; $display("[TB] FAIL edge_lock_wins_state: got %0d want 2", state_o); end
        compared++; if (timeout_cnt !== 8'd3) begin mismatched++; $display("[TB] FAIL edge_tmo_cnt: got %0d want 3", timeout_cnt); end
        compared++; if (pll_rst !== 1'b0) begin mismatched++; $display("[TB] FAIL edge_pll_rst: got %b want 0", pll_rst); end
    endtask

    task automatic test_async_reset;
        step(9);
        compared++; if (state_o !== 3'd3) begin mismatched++; $display("[TB] FAIL arst_in_hold: got %0d want 3", state_o); end
        #3;
        rst = 1'b1;
        #1;
        compared++; if (pll_rst !== 1'b1) begin mismatched++; $display("[TB] FAIL arst_pll_rst: got %b want 1", pll_rst); end
        compared++; if (rst_out !== 1'b1) begin mismatched++; $display("[TB] FAIL arst_rst_out: got %b want 1", rst_out); end
        compared++; if (lock_stable !== 1'b0) begin mismatched++; $display("[TB] FAIL arst_stable: got %b want 0", lock_stable); end
        compared++; if (state_o !== 3'd0) begin mismatched++; $display("[TB] FAIL arst_state: got %0d want 0", state_o); end
        compared++; if (lock_loss_cnt !== 8'd0) begin mismatched++; $display("[TB] FAIL arst_loss_cnt: got %0d want 0", lock_loss_cnt); end
        compared++; if (timeout_cnt !== 8'd0) begin mismatched++; $display("[TB] FAIL arst_tmo_cnt: got %0d want 0", timeout_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4);
        compared++; if (state_o !== 3'd1) begin mismatched++; $display("[TB] FAIL arst_rerun_wait: got %0d want 1", state_o); end
        step(1);
        compared++; if (state_o !== 3'd2) begin mismatched++; $display("[TB] FAIL arst_rerun_debounce: got %0d want 2", state_o); end
    endtask

    initial begin
        $display("[TB] starting pll_lock_rst_gen directed tests");
        test_reset();
        test_lock_acquire();
        test_lock_loss();
        test_loss_saturation();
        test_debounce_glitch();
        test_timeouts();
        test_lock_at_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
